// File: rtl/flash_sample_sequencer_if.sv
// Avalon-MM read-only master bundle between the sample sequencer and the flash controller.
interface flash_sample_sequencer_if #(
  parameter int ADDR_W = 23
) ();
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic [6:0]        flash_mem_burstcount;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_sample_sequencer.sv
// Reads 32-bit flash words and plays one 8-bit sample per tick, buffering one word (two samples).
// Define FLASH_SEQ_LOOP_EN to wrap at the region boundaries; otherwise playback stops at the end.
module flash_sample_sequencer #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_tick,
  input  logic                    play,
  input  logic                    reverse,
  input  logic                    restart,
  flash_sample_sequencer_if.master flash,
  output logic [7:0]              audio_data,
  output logic                    sample_valid,
  output logic                    end_reached,
  output logic                    overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]       buf_word_q, buf_word_d;
  logic              half_q, half_d;
  logic              dir_q, dir_d;
  logic              buf_valid_q, buf_valid_d;
  logic [7:0]        audio_q, audio_d;
  logic              sv_q, sv_d;
  logic              end_q, end_d;
  logic              ovr_q, ovr_d;

  logic [ADDR_W-1:0] adv_addr;
  logic              adv_half;
  logic              adv_wrap;
  logic              ticks_blocked;
  logic              unused_bytes;

  assign unused_bytes = ^{buf_word_q[23:16], buf_word_q[7:0]};

  // Next (word, half) position in the latched direction, with boundary detection.
  always_comb begin
    adv_addr = word_addr_q;
    adv_half = half_q;
    adv_wrap = 1'b0;
    if (!dir_q) begin
      if (!half_q) begin
        adv_half = 1'b1;
      end else if (word_addr_q == END_ADDR) begin
        adv_wrap = 1'b1;
      end else begin
        adv_addr = word_addr_q + 1'b1;
        adv_half = 1'b0;
      end
    end else begin
      if (half_q) begin
        adv_half = 1'b0;
      end else if (word_addr_q == START_ADDR) begin
        adv_wrap = 1'b1;
      end else begin
        adv_addr = word_addr_q - 1'b1;
        adv_half = 1'b1;
      end
    end
`ifdef FLASH_SEQ_LOOP_EN
    if (adv_wrap) begin
      adv_addr = dir_q ? END_ADDR : START_ADDR;
      adv_half = dir_q;
    end
`endif
  end

`ifdef FLASH_SEQ_LOOP_EN
  assign ticks_blocked = 1'b0;
`else
  assign ticks_blocked = end_q;
`endif

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    buf_addr_d  = buf_addr_q;
    buf_word_d  = buf_word_q;
    half_d      = half_q;
    dir_d       = dir_q;
    buf_valid_d = buf_valid_q;
    audio_d     = audio_q;
    sv_d        = 1'b0;
    ovr_d       = ovr_q;
`ifdef FLASH_SEQ_LOOP_EN
    end_d       = 1'b0;
`else
    end_d       = end_q;
`endif

    if (sample_tick && (state_q != S_IDLE)) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        // restart consumes a coincident tick
        if (restart) begin
          word_addr_d = reverse ? END_ADDR : START_ADDR;
          half_d      = reverse;
          buf_valid_d = 1'b0;
          end_d       = 1'b0;
          ovr_d       = 1'b0;
        end else if (sample_tick && play && !ticks_blocked) begin
          dir_d   = reverse;
          state_d = (buf_valid_q && (buf_addr_q == word_addr_q)) ? S_EMIT : S_REQ;
        end
      end
      S_REQ: begin
        if (!flash.flash_mem_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flash.flash_mem_readdatavalid) begin
          buf_word_d  = flash.flash_mem_readdata;
          buf_addr_d  = word_addr_q;
          buf_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        audio_d     = half_q ? buf_word_q[31:24] : buf_word_q[15:8];
        sv_d        = 1'b1;
        word_addr_d = adv_addr;
        half_d      = adv_half;
        if (adv_wrap) end_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      word_addr_q <= START_ADDR;
      buf_addr_q  <= START_ADDR;
      buf_word_q  <= '0;
      half_q      <= 1'b0;
      dir_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      audio_q     <= '0;
      sv_q        <= 1'b0;
      end_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      buf_addr_q  <= buf_addr_d;
      buf_word_q  <= buf_word_d;
      half_q      <= half_d;
      dir_q       <= dir_d;
      buf_valid_q <= buf_valid_d;
      audio_q     <= audio_d;
      sv_q        <= sv_d;
      end_q       <= end_d;
      ovr_q       <= ovr_d;
    end
  end

  assign flash.flash_mem_read       = (state_q == S_REQ);
  assign flash.flash_mem_address    = word_addr_q;
  assign flash.flash_mem_byteenable = 4'hF;
  assign flash.flash_mem_burstcount = 7'd1;

  assign audio_data   = audio_q;
  assign sample_valid = sv_q;
  assign end_reached  = end_q;
  assign overrun      = ovr_q;

endmodule
